seq_sum_reducer: RTL and testbench
==================================

Name: seq_sum_reducer

Overview:
- Consumer end of the SVM parallel adder stage.
- Accepts one packed vector of NUM_EL partial sums per valid/ready handshake, then reduces it to one sum by accumulating one element per clock.
- Delivers the result on a valid/ready output.
- Trades throughput for area: one adder replaces the final combinational adder tree level when the element count is small.

Parameters:
- NUM_EL, 5, number of packed elements per input vector (≥1)
- IN_BW, 20, bit width of each input element
- OUT_BW, 24, accumulator and output width; must be ≥ IN_BW. Overflow-free when OUT_BW ≥ IN_BW+ceil(log2(NUM_EL)).

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid vector
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  NUM_EL*IN_BW  packed elements; element i at bits [i*IN_BW+IN_BW-1 : i*IN_BW]
- out_valid  output  1  out_sum valid
- out_ready  input  1  downstream accepts out_sum
- out_sum  output  OUT_BW  accumulated sum, registered
- busy  output  1  high whenever state ≠ IDLE

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, acc=0, idx=0, out_valid=0, out_sum=0, busy=0.
  - in_ready is forced 0 while rst=1.
- in_ready = (state==IDLE) && !rst, combinational from state.
- Input capture: on an edge with in_valid && in_ready:
  - register the full in_data into a vector holding register;
  - acc <= ext(element 0), idx <= 1.
  - Next state is ACCUM if NUM_EL>1, else DONE.
- ACCUM: each edge, acc <= acc + ext(element idx) and idx <= idx+1.
  - The edge that adds element NUM_EL-1 moves to DONE.
- DONE: out_valid=1 and out_sum=acc, both held stable until out_ready=1.
  - On the edge with out_valid && out_ready: state <= IDLE, out_valid <= 0.
- Latency: out_valid is first high after edge k+NUM_EL-1, where k is the accepting edge.
  - Example: NUM_EL=5, accept at edge k → out_valid after edge k+4.
- Throughput: no overlap; at most one vector per NUM_EL+1 cycles (IDLE cycle is mandatory before the next accept).
- in_valid is ignored outside IDLE. The held copy of in_data is used, so the upstream may change in_data freely after acceptance.
- ext(): zero-extend IN_BW → OUT_BW (default build).
- Arithmetic is modulo 2^OUT_BW; wrap silently when the width rule is violated. No overflow flag.
- idx width is ceil(log2(NUM_EL)) bits, minimum 1. idx never exceeds NUM_EL-1.
- rst in any state aborts the operation: next state IDLE, partial acc discarded, out_valid=0, no result emitted.
- out_ready while out_valid=0 has no effect.
- NUM_EL=1: accept goes directly to DONE with out_sum=ext(element 0).

Optional Feature:
- Macro: SEQ_SUM_REDUCER_SIGNED_EN.
- When defined:
  - Elements are two's-complement and ext() sign-extends IN_BW → OUT_BW.
  - acc and out_sum are interpreted as signed.
- When undefined: unsigned zero-extension as above.
- Latency, handshake and FSM are identical in both builds.

Test Plan (NUM_EL=5, IN_BW=20, OUT_BW=24 unless stated):
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_sum=0, busy=0 throughout. in_ready=1 on the first cycle after rst falls.
- Basic sum: elements {1,2,3,4,5}, out_ready=1 → out_valid after accept edge +4, out_sum=15 (0x00000F) for exactly one cycle. in_ready=1 on the following cycle.
- Max values: all elements 0xFFFFF → out_sum=0x4FFFFB (5242875), no wrap.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with a new vector → out_sum stable, in_ready=0, new vector not accepted. After out_ready=1, the next vector is accepted one cycle later and summed correctly.
- Reset mid-operation: assert rst after element 2 is added → state IDLE next edge, out_valid never asserts. Following vector {10,0,0,0,0} → out_sum=10.
- Signedness: elements {0xFFFFF,3,0,0,0} → 0x100002 without SEQ_SUM_REDUCER_SIGNED_EN; 0x000002 with it defined.

Source files
------------

// File: rtl/seq_sum_reducer_if.sv
// Handshake bundle for seq_sum_reducer: input vector channel, output sum channel, busy flag.
// The slave modport is the reducer side; the master modport is the upstream/downstream side.
interface seq_sum_reducer_if #(
    parameter int unsigned NUM_EL = 5,
    parameter int unsigned IN_BW  = 20,
    parameter int unsigned OUT_BW = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_EL*IN_BW-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_BW-1:0]       out_sum;
    logic                    busy;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_sum,
        output busy
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  busy
    );
endinterface

// File: rtl/seq_sum_reducer.sv
// Sequential reducer: accepts a packed vector of NUM_EL partial sums, adds one element per
// clock into a single accumulator and presents the total on a valid/ready output.
// Optional build macro SEQ_SUM_REDUCER_SIGNED_EN: elements are two's-complement and are
// sign-extended into the accumulator (default build zero-extends).
module seq_sum_reducer #(
    parameter int unsigned NUM_EL = 5,
    parameter int unsigned IN_BW  = 20,
    parameter int unsigned OUT_BW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_sum_reducer_if.slave     bus
);

    localparam int unsigned IdxW = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_EL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [NUM_EL*IN_BW-1:0] r_vec;
    logic [OUT_BW-1:0]       r_acc;
    logic [OUT_BW-1:0]       w_acc_next;
    logic [IdxW-1:0]         r_idx;
    logic [IdxW-1:0]         w_idx_next;
    logic                    w_in_ready;
    logic                    w_accept;
    logic [IN_BW-1:0]        w_elem;

    // Widen one element to accumulator width.
    function automatic logic [OUT_BW-1:0] ext(input logic [IN_BW-1:0] e);
`ifdef SEQ_SUM_REDUCER_SIGNED_EN
        logic signed [IN_BW-1:0]  s_in;
        logic signed [OUT_BW-1:0] s_out;
        s_in  = e;
        s_out = s_in;
        return s_out;
`else
        return OUT_BW'(e);
`endif
    endfunction

    assign w_in_ready = (r_state == StIdle) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Pick element r_idx out of the held vector.
    always_comb begin
        w_elem = r_vec[IN_BW-1:0];
        for (int i = 0; i < NUM_EL; i++) begin
            if (r_idx == IdxW'(i)) begin
                w_elem = r_vec[i*IN_BW +: IN_BW];
            end
        end
    end

    // Next-state, accumulator and index update.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_idx_next   = r_idx;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    // Element 0 comes straight from the bus; the rest from the held copy.
                    w_acc_next = ext(bus.in_data[IN_BW-1:0]);
                    if (NUM_EL > 1) begin
                        w_idx_next   = IdxW'(1);
                        w_state_next = StAccum;
                    end else begin
                        w_idx_next   = '0;
                        w_state_next = StDone;
                    end
                end
            end
            StAccum: begin
                w_acc_next = r_acc + ext(w_elem);
                if (r_idx == LastIdx) begin
                    // Park idx at 0 so it never runs past the last element.
                    w_idx_next   = '0;
                    w_state_next = StDone;
                end else begin
                    w_idx_next = r_idx + IdxW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Control state and accumulator registers with synchronous abort on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_idx   <= w_idx_next;
        end
    end

    // Held copy of the accepted vector so upstream may change in_data after the handshake.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_vec <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == StDone);
    assign bus.out_sum   = r_acc;
    assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_seq_sum_reducer.sv
// Self-checking bench for seq_sum_reducer (NUM_EL=5, IN_BW=20, OUT_BW=24).
// Expected sums are pushed to a scoreboard queue at acceptance and popped at the output.
module tb_seq_sum_reducer;

    localparam int unsigned NUM_EL = 5;
    localparam int unsigned IN_BW  = 20;
    localparam int unsigned OUT_BW = 24;
    localparam int unsigned VW     = NUM_EL * IN_BW;

`ifdef SEQ_SUM_REDUCER_SIGNED_EN
    localparam logic [OUT_BW-1:0] MaxExp  = 24'hFFFFFB;
    localparam logic [OUT_BW-1:0] SignExp = 24'h000002;
`else
    localparam logic [OUT_BW-1:0] MaxExp  = 24'h4FFFFB;
    localparam logic [OUT_BW-1:0] SignExp = 24'h100002;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [OUT_BW-1:0] sb[$];

    seq_sum_reducer_if #(.NUM_EL(NUM_EL), .IN_BW(IN_BW), .OUT_BW(OUT_BW)) bus ();

    seq_sum_reducer #(.NUM_EL(NUM_EL), .IN_BW(IN_BW), .OUT_BW(OUT_BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack5(input logic [IN_BW-1:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    // Reference sum, modulo 2^OUT_BW.
    function automatic logic [OUT_BW-1:0] model_sum(input logic [VW-1:0] v);
        logic [OUT_BW-1:0] acc;
        logic [IN_BW-1:0]  e;
        acc = '0;
        for (int i = 0; i < NUM_EL; i++) begin
            e = v[i*IN_BW +: IN_BW];
`ifdef SEQ_SUM_REDUCER_SIGNED_EN
            acc = acc + {{(OUT_BW-IN_BW){e[IN_BW-1]}}, e};
`else
            acc = acc + {{(OUT_BW-IN_BW){1'b0}}, e};
`endif
        end
        return acc;
    endfunction

    // Present a vector for one edge, then scramble in_data to prove the held copy is used.
    task automatic accept_vec(input logic [VW-1:0] v);
        logic [VW-1:0] junk;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        junk = {$urandom, $urandom, $urandom, $urandom};
        bus.in_data = junk;
    endtask

    // Edges after the current point until out_valid is seen; capped at 30.
    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic [OUT_BW-1:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = pack5(20'd1, 20'd2, 20'd3, 20'd4, 20'd5);
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
            end
            checks++;
            if (bus.out_sum !== 24'h0) begin
                errors++;
                $display("FAIL reset_out_sum: got %h want 000000", bus.out_sum);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy: got %b want 0", bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_sum();
        logic [VW-1:0]     v;
        logic [OUT_BW-1:0] exp;
        int                n;
        v = pack5(20'd1, 20'd2, 20'd3, 20'd4, 20'd5);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b want 1", bus.in_ready);
        end
        sb.push_back(model_sum(v));
        accept_vec(v);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", bus.busy);
        end
        wait_out(n);
        checks++;
        if (n != NUM_EL - 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", n, NUM_EL - 1);
        end
        exp = sb_pop();
        checks++;
        if (bus.out_sum !== exp) begin
            errors++;
            $display("FAIL basic_sum_model: got %h want %h", bus.out_sum, exp);
        end
        checks++;
        if (bus.out_sum !== 24'h00000F) begin
            errors++;
            $display("FAIL basic_sum_const: got %h want 00000f", bus.out_sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got out_valid %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_after: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_max_values();
        logic [VW-1:0]     v;
        logic [OUT_BW-1:0] exp;
        int                n;
        v = pack5(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
        bus.out_ready = 1'b1;
        sb.push_back(model_sum(v));
        accept_vec(v);
        wait_out(n);
        checks++;
        if (n != NUM_EL - 1) begin
            errors++;
            $display("FAIL max_latency: got %0d want %0d", n, NUM_EL - 1);
        end
        exp = sb_pop();
        checks++;
        if (bus.out_sum !== exp) begin
            errors++;
            $display("FAIL max_sum_model: got %h want %h", bus.out_sum, exp);
        end
        checks++;
        if (bus.out_sum !== MaxExp) begin
            errors++;
            $display("FAIL max_sum_const: got %h want %h", bus.out_sum, MaxExp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [VW-1:0]     va;
        logic [VW-1:0]     vb;
        logic [OUT_BW-1:0] exp;
        int                n;
        va = pack5(20'd100, 20'd200, 20'd300, 20'd400, 20'd500);
        vb = pack5(20'h12345, 20'h00111, 20'h0ABCD, 20'h00007, 20'h54321);
        bus.out_ready = 1'b0;
        sb.push_back(model_sum(va));
        accept_vec(va);
        wait_out(n);
        checks++;
        if (n != NUM_EL - 1) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", n, NUM_EL - 1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = vb;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== sb[0]) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid %b sum %h want valid 1 sum %h",
                         i, bus.out_valid, bus.out_sum, sb[0]);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        exp = sb_pop();
        checks++;
        if (bus.out_sum !== exp) begin
            errors++;
            $display("FAIL bp_sum_a: got %h want %h", bus.out_sum, exp);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid %b ready %b want valid 0 ready 1",
                     bus.out_valid, bus.in_ready);
        end
        sb.push_back(model_sum(vb));
        accept_vec(vb);
        wait_out(n);
        checks++;
        if (n != NUM_EL - 1) begin
            errors++;
            $display("FAIL bp_latency_b: got %0d want %0d", n, NUM_EL - 1);
        end
        exp = sb_pop();
        checks++;
        if (bus.out_sum !== exp) begin
            errors++;
            $display("FAIL bp_sum_b: got %h want %h", bus.out_sum, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [OUT_BW-1:0] exp;
        int                n;
        bus.out_ready = 1'b1;
        accept_vec(pack5(20'd7, 20'd8, 20'd9, 20'd11, 20'd13));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: got busy %b valid %b want 0 0", bus.busy, bus.out_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_output[%0d]: got %b want 0", i, bus.out_valid);
            end
        end
        sb.push_back(24'd10);
        accept_vec(pack5(20'd10, 20'd0, 20'd0, 20'd0, 20'd0));
        wait_out(n);
        exp = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== exp) begin
            errors++;
            $display("FAIL mid_next_sum: got valid %b sum %h want valid 1 sum %h",
                     bus.out_valid, bus.out_sum, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signedness();
        logic [VW-1:0]     v;
        logic [OUT_BW-1:0] exp;
        int                n;
        v = pack5(20'hFFFFF, 20'd3, 20'd0, 20'd0, 20'd0);
        bus.out_ready = 1'b1;
        sb.push_back(SignExp);
        accept_vec(v);
        wait_out(n);
        exp = sb_pop();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== exp) begin
            errors++;
            $display("FAIL sign_sum: got valid %b sum %h want valid 1 sum %h",
                     bus.out_valid, bus.out_sum, exp);
        end
        checks++;
        if (bus.out_sum !== model_sum(v)) begin
            errors++;
            $display("FAIL sign_sum_model: got %h want %h", bus.out_sum, model_sum(v));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_max_values();
        test_backpressure();
        test_reset_mid();
        test_signedness();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
